mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 155 +++++++++++++++
 tb/tb_mem_responder.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word-addressed memory responder with fixed-latency handshake
module mem_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 32,
  parameter int          LATENCY   = 2,
  localparam int         IDX_W     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_memory_transaction,
  input  logic             write,
  input  logic [31:0]      address,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic             done_memory_transaction,
  output logic             err,
  output logic             busy,
  input  logic             bd_we,
  input  logic [IDX_W-1:0] bd_addr,
  input  logic [31:0]      bd_data,
  output logic [15:0]      txn_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    RESP  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [3:0]  LAT_M1   = 4'(LATENCY - 1);
  localparam logic [31:0] ERR_WORD = 32'hDEAD_BEEF;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        done_q, done_d;
  logic [15:0] count_q, count_d;
  logic [31:0] mem_q [DEPTH];
  logic [31:0] mem_d [DEPTH];

  logic [32:0]      diff;
  logic [31:0]      offset;
  logic             below_base;
  logic [IDX_W-1:0] idx;
  logic             addr_err;

  // Decode the captured address: the borrow of the 33-bit subtraction flags addresses below the base
  always_comb begin
    diff       = {1'b0, addr_q} - {1'b0, BASE_ADDR};
    below_base = diff[32];
    offset     = diff[31:0];
    idx        = offset[IDX_W+1:2];
    addr_err   = (addr_q[1:0] != 2'b00) || below_base || ((offset >> 2) >= 32'(DEPTH));
  end

  // Next-state, capture, response and memory update logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    done_d  = 1'b0;
    count_d = count_q;
    mem_d   = mem_q;

    if (bd_we) begin
      mem_d[bd_addr] = bd_data;
    end

    case (state_q)
      IDLE: begin
        if (start_memory_transaction) begin
          wr_d    = write;
          addr_d  = address;
          wdata_d = wdata;
          cnt_d   = LAT_M1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        done_d  = 1'b1;
        err_d   = addr_err;
        count_d = count_q + 16'd1;
        if (wr_q) begin
          // bus write is applied after the backdoor so it wins on a collision;
          // reset gating keeps an aborted transaction from committing
          if (!addr_err && rst_n) begin
            mem_d[idx] = wdata_q;
          end
        end else begin
          rdata_d = addr_err ? ERR_WORD : mem_q[idx];
        end
        state_d = DRAIN;
      end
      DRAIN: begin
        if (!start_memory_transaction) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and status registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wr_q    <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      count_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      done_q  <= done_d;
      count_q <= count_d;
    end
  end

  // Memory array keeps its contents through reset
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign rdata                   = rdata_q;
  assign err                     = err_q;
  assign done_memory_transaction = done_q;
  assign txn_count               = count_q;
  assign busy                    = (state_q != IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - randomized and directed checks of mem_responder against a behavioural model
module tb_mem_responder;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 32;
  localparam int          LAT   = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        write;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        err;
  logic        busy;
  logic        bd_we;
  logic [4:0]  bd_addr;
  logic [31:0] bd_data;
  logic [15:0] txn_count;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] m_rdata;
  logic        m_err;
  logic [15:0] m_count;

  int n_checks = 0;
  int n_pass   = 0;

  mem_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start_memory_transaction (start),
    .write                    (write),
    .address                  (address),
    .wdata                    (wdata),
    .rdata                    (rdata),
    .done_memory_transaction  (done),
    .err                      (err),
    .busy                     (busy),
    .bd_we                    (bd_we),
    .bd_addr                  (bd_addr),
    .bd_data                  (bd_data),
    .txn_count                (txn_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_done"},  32'(done), 32'd0);
    check({tag, "_rdata"}, rdata, 32'd0);
    check({tag, "_err"},   32'(err), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_count"}, 32'(txn_count), 32'd0);
  endtask

  task automatic bd_write(input int idx, input logic [31:0] val);
    @(negedge clk);
    bd_we   = 1'b1;
    bd_addr = 5'(idx);
    bd_data = val;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
    model_mem[idx] = val;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("idle_wait", 32'(busy), 32'd0);
  endtask

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d);
    wait_idle();
    @(negedge clk);
    start   = 1'b1;
    write   = w;
    address = a;
    wdata   = d;
  endtask

  // Acceptance happens at the next rising edge; follows the transaction to its done pulse.
  // bd_k > 0 drives a backdoor write on the k-th edge after acceptance.
  task automatic complete(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic hold, input int bd_k, input int bd_idx,
                          input logic [31:0] bd_val);
    logic [31:0] off;
    int          idx;
    logic        e;
    int          lat;
    logic        seen;

    @(posedge clk);
    #1;
    check("busy_after_accept", 32'(busy), 32'd1);
    start   = hold;
    write   = 1'($urandom);
    address = $urandom;
    wdata   = $urandom;

    off = a - BASE;
    idx = int'(off >> 2);
    e   = (a[1:0] != 2'b00) || (longint'(a) < longint'(BASE)) || ((off >> 2) >= 32'(DEPTH));
    if (bd_k > 0 && bd_k <= LAT) model_mem[bd_idx] = bd_val;
    if (w) begin
      if (!e) model_mem[idx] = d;
    end else begin
      m_rdata = e ? 32'hDEAD_BEEF : model_mem[idx];
    end
    if (bd_k == LAT + 1 && !(w && !e && idx == bd_idx)) model_mem[bd_idx] = bd_val;
    m_err   = e;
    m_count = m_count + 16'd1;

    lat  = 0;
    seen = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      if (lat + 1 == bd_k) begin
        bd_we   = 1'b1;
        bd_addr = 5'(bd_idx);
        bd_data = bd_val;
      end else begin
        bd_we = 1'b0;
      end
      @(posedge clk);
      #1;
      bd_we = 1'b0;
      lat++;
      seen = (done === 1'b1);
    end
    check("latency",   32'(lat), 32'(LAT + 1));
    check("rdata",     rdata, m_rdata);
    check("err",       32'(err), 32'(m_err));
    check("txn_count", 32'(txn_count), 32'(m_count));
    @(posedge clk);
    #1;
    check("done_pulse", 32'(done), 32'd0);
  endtask

  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d);
    issue(w, a, d);
    complete(w, a, d, 1'b0, 0, 0, 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        w;

    rst_n   = 1'b0;
    start   = 1'b0;
    write   = 1'b0;
    address = 32'd0;
    wdata   = 32'd0;
    bd_we   = 1'b0;
    bd_addr = 5'd0;
    bd_data = 32'd0;
    m_rdata = 32'd0;
    m_err   = 1'b0;
    m_count = 16'd0;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) bd_write(i, $urandom);

    bd_write(3, 32'h1234_5678);
    txn(1'b0, 32'h0000_000C, 32'd0);
    check("read_word3", rdata, 32'h1234_5678);

    txn(1'b1, 32'h0000_0008, 32'hCAFE_0001);
    txn(1'b0, 32'h0000_0008, 32'd0);
    check("write_then_read", rdata, 32'hCAFE_0001);

    txn(1'b0, 32'h0000_0082, 32'd0);
    txn(1'b0, 32'h0000_0080, 32'd0);
    txn(1'b1, 32'h0000_0080, 32'h5555_AAAA);
    txn(1'b1, 32'h0000_0041, 32'h6666_BBBB);

    issue(1'b0, 32'h0000_001C, 32'd0);
    complete(1'b0, 32'h0000_001C, 32'd0, 1'b0, 2, 7, 32'hA5A5_0707);

    issue(1'b1, 32'h0000_0014, 32'h0B05_B05B);
    complete(1'b1, 32'h0000_0014, 32'h0B05_B05B, 1'b0, 3, 5, 32'hBAD0_0005);
    txn(1'b0, 32'h0000_0014, 32'd0);

    issue(1'b0, 32'h0000_0010, 32'd0);
    complete(1'b0, 32'h0000_0010, 32'd0, 1'b1, 0, 0, 32'd0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check("drain_done", 32'(done), 32'd0);
      check("drain_busy", 32'(busy), 32'd1);
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check("drain_exit", 32'(busy), 32'd0);
    txn(1'b0, 32'h0000_0018, 32'd0);

    issue(1'b1, 32'h0000_0004, 32'h0BAD_0004);
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n   = 1'b0;
    start   = 1'b1;
    write   = 1'b0;
    address = 32'h0000_0004;
    @(posedge clk);
    #1;
    check_reset_outputs("wait_reset");
    m_count = 16'd0;
    m_rdata = 32'd0;
    m_err   = 1'b0;
    @(posedge clk);
    #1;
    check("reset_hold_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    complete(1'b0, 32'h0000_0004, 32'd0, 1'b0, 0, 0, 32'd0);

    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom);
      d = $urandom;
      case ($urandom_range(0, 9))
        0:       a = 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
        1:       a = 32'h0000_0080 + 32'($urandom_range(0, 63)) * 4;
        2:       a = $urandom | 32'h1000_0000;
        default: a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
      txn(w, a, d);
    end

    for (int i = 0; i < DEPTH; i++) begin
      txn(1'b0, 32'(i) * 4, 32'd0);
    end

    @(negedge clk);
    force dut.count_q = 16'hFFFE;
    @(posedge clk);
    #1;
    @(negedge clk);
    release dut.count_q;
    m_count = 16'hFFFE;
    @(posedge clk);
    #1;
    check("count_preset", 32'(txn_count), 32'h0000_FFFE);
    txn(1'b0, 32'h0000_0000, 32'd0);
    txn(1'b1, 32'h0000_0000, 32'h7777_0000);
    check("count_wrap", 32'(txn_count), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
